// File: rtl/gb_pkg.sv
// Shared types and constants for the bus-local decoder.
package gb_pkg;

    // Region an address falls into; NONE marks "no read response pending".
    typedef enum logic [2:0] {
        NONE,
        LOCAL_CSR,
        LOCAL_RAM,
        LOCAL_ERR,
        SUB,
        UNMAPPED
    } region_t;

    localparam logic [31:0] DEADBEEF  = 32'hDEADBEEF;
    localparam int          ERR_CNT_W = 16;

endpackage

// File: rtl/gb_addr_decode.sv
// Combinational word-address classifier: local CSR / RAM / error counter,
// subordinate window, or unmapped, plus the index within that region.
module gb_addr_decode
    import gb_pkg::*;
#(
    parameter int AW       = 12,
    parameter int NCSR     = 4,
    parameter int RAM_AW   = 3,
    parameter int RAM_BASE = 'h40,
    parameter int LOCAL_AW = 7,
    parameter int NSUB     = 2,
    parameter int SUB_AW   = 10,
    parameter int CSR_IW   = (NCSR > 1) ? $clog2(NCSR) : 1,
    parameter int SUB_IW   = (NSUB > 1) ? $clog2(NSUB) : 1
) (
    input  logic [AW-1:0]     addr,
    output region_t           region,
    output logic [CSR_IW-1:0] csr_idx,
    output logic [RAM_AW-1:0] ram_idx,
    output logic [SUB_IW-1:0] sub_idx
);

    localparam int WIN_W = AW - SUB_AW;

    localparam logic [AW-1:0]    LOCAL_END = AW'(2**LOCAL_AW);
    localparam logic [AW-1:0]    ERR_ADDR  = AW'(2**LOCAL_AW - 1);
    localparam logic [AW-1:0]    CSR_END   = AW'(NCSR);
    localparam logic [AW-1:0]    RAM_LO    = AW'(RAM_BASE);
    localparam logic [AW-1:0]    RAM_HI    = AW'(RAM_BASE + 2**RAM_AW);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(NSUB);

    logic [WIN_W-1:0] win;

    assign win = addr[AW-1:SUB_AW];

    // Window 0 holds the local region; windows 1..NSUB map to subordinates.
    always_comb begin
        region  = UNMAPPED;
        csr_idx = addr[CSR_IW-1:0];
        ram_idx = addr[RAM_AW-1:0];
        sub_idx = SUB_IW'(win - WIN_W'(1));
        if (addr < LOCAL_END) begin
            if (addr < CSR_END) begin
                region = LOCAL_CSR;
            end else if (addr >= RAM_LO && addr < RAM_HI) begin
                region = LOCAL_RAM;
            end else if (addr == ERR_ADDR) begin
                region = LOCAL_ERR;
            end
        end else if (win != '0 && win <= WIN_LAST) begin
            region = SUB;
        end
    end

endmodule

// File: rtl/gb_local_decoder.sv
// Bus-local decoder: CSR bank, small RAM, unmapped-access counter and
// pass-through subordinate channels behind a single-cycle read bus.
module gb_local_decoder
    import gb_pkg::*;
#(
    parameter int                    AW       = 12,
    parameter int                    DW       = 32,
    parameter int                    NCSR     = 4,
    parameter int                    CSR_W    = 8,
    parameter logic [NCSR*CSR_W-1:0] CSR_INIT = '0,
    parameter int                    RAM_AW   = 3,
    parameter int                    RAM_DW   = 4,
    parameter int                    RAM_BASE = 'h40,
    parameter int                    LOCAL_AW = 7,
    parameter int                    NSUB     = 2,
    parameter int                    SUB_AW   = 10
) (
    input  logic                  gb_clk,
    input  logic                  gb_rst,
    input  logic [AW-1:0]         gb_addr,
    input  logic [DW-1:0]         gb_dout,
    input  logic                  gb_we,
    input  logic                  gb_re,
    output logic [DW-1:0]         gb_din,
    output logic                  gb_rvalid,
    output logic [NCSR*CSR_W-1:0] csr_q,
    output logic [NCSR-1:0]       csr_ws,
    output logic [NCSR-1:0]       csr_rs,
    input  logic [NCSR-1:0]       csr_ld,
    input  logic [NCSR*CSR_W-1:0] csr_ld_val,
    input  logic [RAM_AW-1:0]     ram_raddr,
    output logic [RAM_DW-1:0]     ram_rdata,
    output logic [NSUB*AW-1:0]    sub_addr,
    output logic [NSUB*DW-1:0]    sub_dout,
    output logic [NSUB-1:0]       sub_we,
    output logic [NSUB-1:0]       sub_re,
    input  logic [NSUB*DW-1:0]    sub_din
);

    localparam int CSR_IW = (NCSR > 1) ? $clog2(NCSR) : 1;
    localparam int SUB_IW = (NSUB > 1) ? $clog2(NSUB) : 1;

    // Reject parameter sets whose address map is inconsistent.
    if (LOCAL_AW > SUB_AW) begin : g_bad_local_aw
        $error("local region is larger than one subordinate window");
    end
    if ((NSUB + 1) * (2**SUB_AW) > 2**AW) begin : g_bad_sub_map
        $error("subordinate windows do not fit in the bus address space");
    end
    if (CSR_W > DW) begin : g_bad_csr_w
        $error("CSR wider than bus data");
    end
    if (RAM_DW > DW) begin : g_bad_ram_dw
        $error("RAM word wider than bus data");
    end
    if (RAM_BASE % (2**RAM_AW) != 0) begin : g_bad_ram_align
        $error("RAM base not aligned to RAM size");
    end
    if (NCSR > RAM_BASE) begin : g_bad_csr_ram
        $error("CSR words overlap RAM words");
    end
    if (RAM_BASE + 2**RAM_AW > 2**LOCAL_AW - 1) begin : g_bad_ram_err
        $error("RAM words overlap the error counter word");
    end
    if (NCSR > 2**LOCAL_AW - 1) begin : g_bad_csr_err
        $error("CSR words overlap the error counter word");
    end

    region_t             dec_region;
    logic [CSR_IW-1:0]   dec_csr_idx;
    logic [RAM_AW-1:0]   dec_ram_idx;
    logic [SUB_IW-1:0]   dec_sub_idx;

    logic                wr_en;
    logic                rd_en;

    logic [CSR_W-1:0]    csr_val_q [NCSR];
    logic [CSR_W-1:0]    csr_val_d [NCSR];
    logic [NCSR-1:0]     csr_ws_q, csr_ws_d;
    logic [NCSR-1:0]     csr_rs_q, csr_rs_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                rvalid_q, rvalid_d;
    region_t             sel_q, sel_d;
    logic [SUB_IW-1:0]   sub_sel_q, sub_sel_d;
    logic [DW-1:0]       rdata_q, rdata_d;

    logic [RAM_DW-1:0]   mem [2**RAM_AW];
    logic [RAM_DW-1:0]   ram_rdata_q, ram_rdata_d;

    gb_addr_decode #(
        .AW       (AW),
        .NCSR     (NCSR),
        .RAM_AW   (RAM_AW),
        .RAM_BASE (RAM_BASE),
        .LOCAL_AW (LOCAL_AW),
        .NSUB     (NSUB),
        .SUB_AW   (SUB_AW),
        .CSR_IW   (CSR_IW),
        .SUB_IW   (SUB_IW)
    ) u_decode (
        .addr    (gb_addr),
        .region  (dec_region),
        .csr_idx (dec_csr_idx),
        .ram_idx (dec_ram_idx),
        .sub_idx (dec_sub_idx)
    );

    // A write and a read in the same cycle is treated as a write only.
    assign wr_en = gb_we;
    assign rd_en = gb_re & ~gb_we;

    // Subordinate channels are pure pass-through, gated by window hit.
    always_comb begin
        for (int k = 0; k < NSUB; k++) begin
            sub_addr[k*AW +: AW] = gb_addr - AW'((k + 1) * (2**SUB_AW));
            sub_dout[k*DW +: DW] = gb_dout;
            sub_we[k] = wr_en && dec_region == SUB && dec_sub_idx == SUB_IW'(k);
            sub_re[k] = rd_en && dec_region == SUB && dec_sub_idx == SUB_IW'(k);
        end
    end

    // Next-state for CSRs, strobes, error counter and the read pipeline stage.
    always_comb begin
        for (int i = 0; i < NCSR; i++) begin
            csr_val_d[i] = csr_val_q[i];
        end
        csr_ws_d  = '0;
        csr_rs_d  = '0;
        err_cnt_d = err_cnt_q;
        rvalid_d  = 1'b0;
        sel_d     = NONE;
        sub_sel_d = dec_sub_idx;
        rdata_d   = '0;

        // Fabric load first so that a host write to the same CSR overrides it.
        for (int i = 0; i < NCSR; i++) begin
            if (csr_ld[i]) begin
                csr_val_d[i] = csr_ld_val[i*CSR_W +: CSR_W];
            end
            if (dec_region == LOCAL_CSR && dec_csr_idx == CSR_IW'(i)) begin
                if (wr_en) begin
                    csr_val_d[i] = gb_dout[CSR_W-1:0];
                    csr_ws_d[i]  = 1'b1;
                end
                if (rd_en) begin
                    csr_rs_d[i] = 1'b1;
                end
            end
        end

        if (wr_en && dec_region == LOCAL_ERR) begin
            err_cnt_d = '0;
        end else if ((wr_en || rd_en) && dec_region == UNMAPPED && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end

        if (rd_en) begin
            rvalid_d = 1'b1;
            sel_d    = dec_region;
            case (dec_region)
                LOCAL_CSR: rdata_d = DW'(csr_val_q[dec_csr_idx]);
                LOCAL_RAM: rdata_d = DW'(mem[dec_ram_idx]);
                LOCAL_ERR: rdata_d = DW'(err_cnt_q);
                UNMAPPED:  rdata_d = DW'(DEADBEEF);
                default:   rdata_d = '0;
            endcase
        end
    end

    // Control and read-pipeline registers with synchronous reset.
    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            for (int i = 0; i < NCSR; i++) begin
                csr_val_q[i] <= CSR_INIT[i*CSR_W +: CSR_W];
            end
            csr_ws_q  <= '0;
            csr_rs_q  <= '0;
            err_cnt_q <= '0;
            rvalid_q  <= 1'b0;
            sel_q     <= NONE;
            sub_sel_q <= '0;
            rdata_q   <= '0;
        end else begin
            for (int i = 0; i < NCSR; i++) begin
                csr_val_q[i] <= csr_val_d[i];
            end
            csr_ws_q  <= csr_ws_d;
            csr_rs_q  <= csr_rs_d;
            err_cnt_q <= err_cnt_d;
            rvalid_q  <= rvalid_d;
            sel_q     <= sel_d;
            sub_sel_q <= sub_sel_d;
            rdata_q   <= rdata_d;
        end
    end

    // Fabric read port samples the array before this edge's write lands.
    always_comb begin
        ram_rdata_d = mem[ram_raddr];
    end

    // RAM storage and fabric read register; contents survive reset.
    always_ff @(posedge gb_clk) begin
        if (wr_en && dec_region == LOCAL_RAM) begin
            mem[dec_ram_idx] <= gb_dout[RAM_DW-1:0];
        end
        ram_rdata_q <= ram_rdata_d;
    end

    // Read data mux: subordinate data arrives late, so it is picked here by the registered select.
    always_comb begin
        gb_din = '0;
        if (rvalid_q) begin
            if (sel_q == SUB) begin
                gb_din = sub_din[sub_sel_q*DW +: DW];
            end else begin
                gb_din = rdata_q;
            end
        end
    end

    // Output packing.
    always_comb begin
        for (int i = 0; i < NCSR; i++) begin
            csr_q[i*CSR_W +: CSR_W] = csr_val_q[i];
        end
    end

    assign csr_ws    = csr_ws_q;
    assign csr_rs    = csr_rs_q;
    assign gb_rvalid = rvalid_q;
    assign ram_rdata = ram_rdata_q;

endmodule

// File: tb/tb_gb_local_decoder.sv
// Randomized scoreboard bench for gb_local_decoder with a behavioural map model.
module tb_gb_local_decoder;

    localparam int AW = 12, DW = 32, NCSR = 4, CSR_W = 8;
    localparam int RAM_AW = 3, RAM_DW = 4, NSUB = 2, SUB_AW = 10;
    localparam logic [31:0] INIT = {8'h42, 8'h00, 8'h00, 8'h00};

    logic        clk;
    logic        gb_rst;
    logic [11:0] gb_addr;
    logic [31:0] gb_dout;
    logic        gb_we, gb_re;
    logic [31:0] gb_din;
    logic        gb_rvalid;
    logic [31:0] csr_q;
    logic [3:0]  csr_ws, csr_rs, csr_ld;
    logic [31:0] csr_ld_val;
    logic [2:0]  ram_raddr;
    logic [3:0]  ram_rdata;
    logic [23:0] sub_addr;
    logic [63:0] sub_dout;
    logic [1:0]  sub_we, sub_re;
    logic [63:0] sub_din;

    gb_local_decoder #(
        .AW(AW), .DW(DW), .NCSR(NCSR), .CSR_W(CSR_W), .CSR_INIT(INIT),
        .RAM_AW(RAM_AW), .RAM_DW(RAM_DW), .RAM_BASE('h40), .LOCAL_AW(7),
        .NSUB(NSUB), .SUB_AW(SUB_AW)
    ) dut (
        .gb_clk(clk), .gb_rst(gb_rst), .gb_addr(gb_addr), .gb_dout(gb_dout),
        .gb_we(gb_we), .gb_re(gb_re), .gb_din(gb_din), .gb_rvalid(gb_rvalid),
        .csr_q(csr_q), .csr_ws(csr_ws), .csr_rs(csr_rs), .csr_ld(csr_ld),
        .csr_ld_val(csr_ld_val), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .sub_addr(sub_addr), .sub_dout(sub_dout), .sub_we(sub_we), .sub_re(sub_re),
        .sub_din(sub_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] din;
        logic [3:0]  rs;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t rd_q[$];

    logic [7:0] csr_m [4];
    logic [3:0] mem_m [8];
    bit   [7:0] mem_ok;
    int         err_m;
    logic [3:0] exp_ws;
    logic [3:0] exp_ram;
    bit         ram_chk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int k, input logic [11:0] off);
        return {8'hCA, 8'(k + 1), 6'h0, off[9:0]};
    endfunction

    // 0 csr, 1 ram, 2 error counter, 3 subordinate, 4 unmapped
    function automatic int kind(input logic [11:0] a, output int idx);
        int ai;
        ai  = int'(a);
        idx = 0;
        if (ai < 4) begin idx = ai; return 0; end
        if (ai >= 'h40 && ai < 'h48) begin idx = ai - 'h40; return 1; end
        if (ai == 'h7F) return 2;
        if (ai >= 'h400 && ai < 'hC00) begin idx = ai / 1024 - 1; return 3; end
        return 4;
    endfunction

    // Behavioural subordinates: one-cycle read latency keyed on their offset.
    always @(posedge clk) begin
        for (int k = 0; k < NSUB; k++) begin
            if (sub_re[k]) sub_din[k*32 +: 32] <= pat(k, sub_addr[k*12 +: 12]);
        end
    end

    // Monitor: compare state every cycle, pop scoreboard on each read response.
    always @(negedge clk) begin
        exp_t e;
        chk("csr_q", csr_q, {csr_m[3], csr_m[2], csr_m[1], csr_m[0]});
        chk("csr_ws", {28'h0, csr_ws}, {28'h0, exp_ws});
        if (ram_chk) chk("ram_rdata", {28'h0, ram_rdata}, {28'h0, exp_ram});
        if (gb_rvalid) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid: unexpected response din=%h, expected none at %0t", gb_din, $time);
            end else begin
                e = rd_q.pop_front();
                chk("gb_din", gb_din, e.din);
                chk("csr_rs", {28'h0, csr_rs}, {28'h0, e.rs});
            end
        end else begin
            chk("gb_din_idle", gb_din, 32'h0);
            chk("csr_rs_idle", {28'h0, csr_rs}, 32'h0);
        end
    end

    task automatic do_op(input bit we, input bit re, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] ld, input logic [31:0] ldv, input logic [2:0] rra);
        int   k, idx;
        exp_t e;
        logic [3:0] ws;
        @(negedge clk);
        #1;
        gb_we = we; gb_re = re; gb_addr = a; gb_dout = d;
        csr_ld = ld; csr_ld_val = ldv; ram_raddr = rra;
        ram_chk = mem_ok[rra];
        exp_ram = mem_m[rra];
        k  = kind(a, idx);
        ws = '0;
        if (re && !we) begin
            case (k)
                0:       e.din = {24'h0, csr_m[idx]};
                1:       e.din = {28'h0, mem_m[idx]};
                2:       e.din = err_m;
                3:       e.din = pat(idx, 12'(int'(a) - (idx + 1) * 1024));
                default: e.din = 32'hDEADBEEF;
            endcase
            e.rs = (k == 0) ? 4'(1 << idx) : 4'h0;
            rd_q.push_back(e);
        end
        for (int i = 0; i < 4; i++) if (ld[i]) csr_m[i] = ldv[i*8 +: 8];
        if (we) begin
            case (k)
                0: begin csr_m[idx] = d[7:0]; ws[idx] = 1'b1; end
                1: begin mem_m[idx] = d[3:0]; mem_ok[idx] = 1'b1; end
                2: err_m = 0;
                default: ;
            endcase
        end
        if ((we || re) && k == 4 && err_m < 65535) err_m++;
        exp_ws = ws;
        #1;
        for (int s = 0; s < NSUB; s++) begin
            chk("sub_re", {31'h0, sub_re[s]}, {31'h0, (re && !we && k == 3 && idx == s)});
            chk("sub_we", {31'h0, sub_we[s]}, {31'h0, (we && k == 3 && idx == s)});
            chk("sub_addr", {20'h0, sub_addr[s*12 +: 12]}, {20'h0, 12'(int'(a) - (s + 1) * 1024)});
            chk("sub_dout", sub_dout[s*32 +: 32], d);
        end
    endtask

    task automatic idle(input logic [2:0] rra);
        do_op(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 32'h0, rra);
    endtask

    task automatic do_reset(input bit with_read);
        @(negedge clk);
        #1;
        gb_rst = 1'b1; gb_we = 1'b0; gb_re = with_read; gb_addr = 12'h001; csr_ld = '0;
        for (int i = 0; i < 4; i++) csr_m[i] = INIT[i*8 +: 8];
        err_m = 0; exp_ws = '0; ram_chk = 1'b0;
        @(negedge clk);
        #1;
        gb_re = 1'b0;
        @(negedge clk);
        #1;
        gb_rst = 1'b0;
    endtask

    function automatic logic [11:0] rand_addr();
        case ($urandom_range(0, 6))
            0:       return 12'($urandom_range(0, 3));
            1:       return 12'('h40 + $urandom_range(0, 7));
            2:       return 12'h07F;
            3:       return 12'($urandom_range('h400, 'hBFF));
            4:       return 12'($urandom_range('hC00, 'hFFF));
            5:       return 12'($urandom_range(4, 'h3F));
            default: return 12'($urandom_range('h48, 'h3FF));
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        gb_rst = 1'b1; gb_we = 1'b0; gb_re = 1'b0; gb_addr = '0; gb_dout = '0;
        csr_ld = '0; csr_ld_val = '0; ram_raddr = '0; sub_din = '0;
        for (int i = 0; i < 4; i++) csr_m[i] = INIT[i*8 +: 8];
        for (int i = 0; i < 8; i++) mem_m[i] = '0;
        mem_ok = '0; err_m = 0; exp_ws = '0; exp_ram = '0; ram_chk = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        gb_rst = 1'b0;
        chk("reset_csr3", {24'h0, csr_q[31:24]}, 32'h42);
        chk("reset_rvalid", {31'h0, gb_rvalid}, 32'h0);
        chk("reset_din", gb_din, 32'h0);

        // CSR write / read back with strobes
        do_op(1, 0, 12'h001, 32'h000000A5, 4'h0, 32'h0, 3'd0);
        do_op(0, 1, 12'h001, 32'h0, 4'h0, 32'h0, 3'd0);
        // host write beats fabric load; load alone on another CSR
        do_op(1, 0, 12'h000, 32'h00000011, 4'b0001, 32'h00000022, 3'd0);
        do_op(0, 0, 12'h000, 32'h0, 4'b0100, 32'h00770000, 3'd0);
        do_op(0, 1, 12'h000, 32'h0, 4'h0, 32'h0, 3'd0);
        do_op(0, 1, 12'h002, 32'h0, 4'h0, 32'h0, 3'd0);
        // fill RAM, 'h45 = 9, then fabric and host reads
        for (int i = 0; i < 8; i++)
            do_op(1, 0, 12'('h40 + i), (i == 5) ? 32'h9 : $urandom, 4'h0, 32'h0, 3'd0);
        idle(3'd5);
        do_op(0, 1, 12'h045, 32'h0, 4'h0, 32'h0, 3'd5);
        // subordinate 1 read and a write+read collision (read dropped)
        do_op(0, 1, 12'h805, 32'h0, 4'h0, 32'h0, 3'd1);
        do_op(1, 1, 12'h003, 32'h0000005C, 4'h0, 32'h0, 3'd2);
        do_op(1, 1, 12'h405, 32'h12345678, 4'h0, 32'h0, 3'd2);
        // unmapped reads and error counter
        repeat (3) do_op(0, 1, 12'hC00, 32'h0, 4'h0, 32'h0, 3'd3);
        do_op(0, 1, 12'h07F, 32'h0, 4'h0, 32'h0, 3'd3);
        do_op(1, 0, 12'h07F, 32'hFFFF, 4'h0, 32'h0, 3'd3);
        do_op(0, 1, 12'h07F, 32'h0, 4'h0, 32'h0, 3'd3);
        // read issued in the reset cycle must be dropped
        do_reset(1'b1);
        idle(3'd4);

        for (int n = 0; n < 1500; n++) begin
            bit w, r;
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1) == 1);
            do_op(w, r, rand_addr(), $urandom, 4'($urandom & $urandom & $urandom),
                  $urandom, 3'($urandom_range(0, 7)));
        end
        do_op(0, 1, 12'h07F, 32'h0, 4'h0, 32'h0, 3'd0);

        // counter saturation
        do_reset(1'b0);
        for (int n = 0; n < 70000; n++)
            do_op(0, 1, 12'($urandom_range('hC00, 'hFFF)), 32'h0, 4'h0, 32'h0,
                  3'($urandom_range(0, 7)));
        do_op(0, 1, 12'h07F, 32'h0, 4'h0, 32'h0, 3'd0);
        idle(3'd0);
        idle(3'd0);

        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL rd_queue: %0d responses outstanding, expected 0", rd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
